bram_port_initiator: RTL and testbench

Request-driven initiator for one port of the 2048x8 dual-port block RAM wrapper. It accepts single-beat write requests and burst read requests on a valid/ready command channel. It drives the RAM port signals `A/D/WE/WEM/CE` from registers and captures `Q` into a response FIFO. Read data is returned in order on a valid/ready response channel, with credit-based flow control so that no in-flight data is ever dropped. One instance sits in front of each RAM port used by an accelerator datapath.

---
 rtl/bram_init_pkg.sv | 14 +
 rtl/bram_rsp_fifo.sv | 59 +++++
 rtl/bram_port_initiator.sv | 182 ++++++++++++++++++
 tb/tb_bram_port_initiator.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_init_pkg.sv
// Shared types and default widths for the block RAM port initiator.
// Holds the FSM state enum and the default RAM geometry constants.
package bram_init_pkg;

  localparam int BRAM_ADDR_W = 11;
  localparam int BRAM_DATA_W = 8;
  localparam int BRAM_LEN_W  = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RD   = 1'b1
  } bram_init_state_t;

endpackage

// File: rtl/bram_rsp_fifo.sv
// Synchronous response FIFO, DEPTH x W, with occupancy count output.
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i, pop_i/data_o,
// empty_o, count_o.  Push and pop may coincide, including when full.
module bram_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign pop     = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop);
    if (push_i)
      wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (pop)
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i)
      mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/bram_port_initiator.sv
// Command-driven initiator for one port of a dual-port block RAM.
// Ports: CLK/RST (sync, active-high); req_* command channel (valid/ready,
// write or burst read); rsp_* in-order read data with rsp_last; registered
// RAM drive A/D/WE/WEM/CE with read data Q; busy.  Defining BRAM_INIT_WEM_EN
// adds req_wem and registers WEM from it; otherwise writes use an all-ones
// mask.
module bram_port_initiator
  import bram_init_pkg::*;
#(
  parameter int ADDR_W    = BRAM_ADDR_W,
  parameter int DATA_W    = BRAM_DATA_W,
  parameter int LEN_W     = BRAM_LEN_W,
  parameter int RSP_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_data,
`ifdef BRAM_INIT_WEM_EN
  input  logic [DATA_W-1:0] req_wem,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              WE,
  output logic [DATA_W-1:0] WEM,
  output logic              CE,
  input  logic [DATA_W-1:0] Q,
  output logic              busy
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  bram_init_state_t  state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [DATA_W-1:0] wem_q, wem_d;
  logic              we_q, we_d;
  logic              ce_q, ce_d;
  logic              tag0_q, tag0_d;
  logic              last0_q, last0_d;
  logic              tag1_q, last1_q;

  logic [CW-1:0]     f_cnt;
  logic              f_empty;
  logic [DATA_W:0]   f_data;
  logic              pop;
  logic [CW+1:0]     occ;
  logic              credit;
  logic              accept;
  logic [DATA_W-1:0] wr_mask;

`ifdef BRAM_INIT_WEM_EN
  assign wr_mask = req_wem;
`else
  assign wr_mask = '1;
`endif

  // A slot freed by this cycle's pop is reusable: the beat issued now
  // lands in the FIFO two cycles later.
  assign pop    = ~f_empty & rsp_ready;
  assign occ    = (CW+2)'(f_cnt) + (CW+2)'(tag0_q)
                + (CW+2)'(tag1_q) - (CW+2)'(pop);
  assign credit = occ < (CW+2)'(RSP_DEPTH);

  assign req_ready = ~RST & (state_q == IDLE)
                   & (~req_valid | req_write | credit);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    d_d     = d_q;
    wem_d   = '0;
    we_d    = 1'b0;
    ce_d    = 1'b0;
    tag0_d  = 1'b0;
    last0_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ce_d = 1'b1;
          a_d  = req_addr;
          if (req_write) begin
            we_d  = 1'b1;
            d_d   = req_data;
            wem_d = wr_mask;
          end else begin
            tag0_d  = 1'b1;
            last0_d = (req_len == '0);
            addr_d  = req_addr + ADDR_W'(1);
            cnt_d   = req_len;
            if (req_len != '0)
              state_d = RD;
          end
        end
      end
      RD: begin
        if (credit) begin
          ce_d   = 1'b1;
          a_d    = addr_q;
          tag0_d = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            last0_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      d_q     <= '0;
      wem_q   <= '0;
      we_q    <= 1'b0;
      ce_q    <= 1'b0;
      tag0_q  <= 1'b0;
      last0_q <= 1'b0;
      tag1_q  <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      d_q     <= d_d;
      wem_q   <= wem_d;
      we_q    <= we_d;
      ce_q    <= ce_d;
      tag0_q  <= tag0_d;
      last0_q <= last0_d;
      tag1_q  <= tag0_q;
      last1_q <= last0_q;
    end
  end

  // tag1 marks the cycle in which Q holds the tagged beat.
  bram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (DATA_W + 1),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (tag1_q),
    .data_i  ({last1_q, Q}),
    .pop_i   (pop),
    .data_o  (f_data),
    .empty_o (f_empty),
    .count_o (f_cnt)
  );

  assign A         = a_q;
  assign D         = d_q;
  assign WE        = we_q;
  assign WEM       = wem_q;
  assign CE        = ce_q;
  assign rsp_valid = ~f_empty;
  assign rsp_data  = f_empty ? '0 : f_data[DATA_W-1:0];
  assign rsp_last  = ~f_empty & f_data[DATA_W];
  assign busy      = (state_q == RD) | tag0_q | tag1_q | ~f_empty;

endmodule

// File: tb/tb_bram_port_initiator.sv
// Scoreboard bench for bram_port_initiator with a behavioural 2048x8 RAM.
// Honours BRAM_INIT_WEM_EN when defined.
module tb_bram_port_initiator;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] req_data, req_wem;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] A;
  logic [DW-1:0] D, WEM, Q;
  logic          WE, CE, busy;

  logic [DW-1:0] ram  [2048];
  logic [DW-1:0] refm [2048];
  logic [DW:0]   exp_q [$];
  logic [DW:0]   e;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  bram_port_initiator #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RSP_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .req_data(req_data),
`ifdef BRAM_INIT_WEM_EN
    .req_wem(req_wem),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last),
    .A(A), .D(D), .WE(WE), .WEM(WEM), .CE(CE),
    .Q(Q), .busy(busy)
  );

  always @(posedge CLK) begin
    if (CE) begin
      if (WE) ram[A] <= (ram[A] & ~WEM) | (D & WEM);
      else    Q <= ram[A];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e[DW-1:0]));
        chk("rsp_last", 32'(rsp_last), 32'(e[DW]));
      end
    end
  end

  task automatic send(input logic wr, input logic [AW-1:0] addr,
                      input logic [LW-1:0] len, input logic [DW-1:0] data,
                      input logic [DW-1:0] wem);
    logic ok;
    logic [DW-1:0] m;
    logic [AW-1:0] a;
    ok = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    req_data  = data;
    req_wem   = wem;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (ok) begin
      if (wr) begin
`ifdef BRAM_INIT_WEM_EN
        m = wem;
`else
        m = '1;
`endif
        refm[addr] = (refm[addr] & ~m) | (data & m);
      end else begin
        for (int b = 0; b <= int'(len); b++) begin
          a = addr + AW'(b);
          exp_q.push_back({(b == int'(len)), refm[a]});
        end
      end
      @(posedge CLK);
      @(negedge CLK);
    end else begin
      chk("accept_timeout", 32'(ok), 32'd1);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy && exp_q.size() == 0) break;
      @(negedge CLK);
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_sb", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_CE"}, 32'(CE), 32'd0);
    chk({p, "_WE"}, 32'(WE), 32'd0);
    chk({p, "_A"}, 32'(A), 32'd0);
    chk({p, "_D"}, 32'(D), 32'd0);
    chk({p, "_WEM"}, 32'(WEM), 32'd0);
    chk({p, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({p, "_rsp_last"}, 32'(rsp_last), 32'd0);
    chk({p, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({p, "_busy"}, 32'(busy), 32'd0);
    chk({p, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce_n;
    int seen;
    logic [AW-1:0] ea;
    for (int i = 0; i < 2048; i++) begin
      ram[i]  = '0;
      refm[i] = '0;
    end
    Q = '0;
    RST = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_len = '0;
    req_data = '0;
    req_wem = '0;
    rsp_ready = 1'b1;

    @(negedge CLK);
    @(negedge CLK);
    chk_rst("reset");
    RST = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    @(negedge CLK);

    // write then single read with latency check
    send(1'b1, 11'h010, 8'd0, 8'h5A, 8'hFF);
    chk("wr_CE", 32'(CE), 32'd1);
    chk("wr_WE", 32'(WE), 32'd1);
    chk("wr_A", 32'(A), 32'h010);
    chk("wr_D", 32'(D), 32'h5A);
    send(1'b0, 11'h010, 8'd0, 8'h00, 8'h00);
    chk("rd_CE", 32'(CE), 32'd1);
    chk("rd_WE", 32'(WE), 32'd0);
    chk("rd_WEM", 32'(WEM), 32'd0);
    @(negedge CLK);
    chk("rd_lat_k2", 32'(rsp_valid), 32'd0);
    @(negedge CLK);
    chk("rd_lat_k3", 32'(rsp_valid), 32'd1);
    chk("rd_data_5a", 32'(rsp_data), 32'h5A);
    chk("rd_last", 32'(rsp_last), 32'd1);
    wait_idle();

    // wrapping burst
    send(1'b1, 11'd2046, 8'd0, 8'h11, 8'hFF);
    send(1'b1, 11'd2047, 8'd0, 8'h22, 8'hFF);
    send(1'b1, 11'd0, 8'd0, 8'h33, 8'hFF);
    send(1'b1, 11'd1, 8'd0, 8'h44, 8'hFF);
    send(1'b0, 11'd2046, 8'd3, 8'h00, 8'h00);
    for (int b = 0; b < 4; b++) begin
      ea = 11'd2046 + AW'(b);
      chk("wrap_CE", 32'(CE), 32'd1);
      chk("wrap_A", 32'(A), 32'(ea));
      @(negedge CLK);
    end
    chk("wrap_CE_end", 32'(CE), 32'd0);
    wait_idle();

    // backpressure on an 8-beat burst
    for (int i = 0; i < 8; i++)
      send(1'b1, 11'h100 + AW'(i), 8'd0, 8'h30 + DW'(i * 7), 8'hFF);
    rsp_ready = 1'b0;
    send(1'b0, 11'h100, 8'd7, 8'h00, 8'h00);
    ce_n = 0;
    for (int i = 0; i < 12; i++) begin
      ce_n += int'(CE);
      @(negedge CLK);
    end
    chk("bp_ce_count", 32'(ce_n), 32'd4);
    chk("bp_CE_low", 32'(CE), 32'd0);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    wait_idle();

    // credit gate in IDLE: full FIFO blocks reads but not writes
    rsp_ready = 1'b0;
    send(1'b0, 11'h100, 8'd3, 8'h00, 8'h00);
    repeat (4) @(negedge CLK);
    chk("cg_busy", 32'(busy), 32'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    #1;
    chk("cg_read_blocked", 32'(req_ready), 32'd0);
    req_write = 1'b1;
    #1;
    chk("cg_write_ok", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    @(negedge CLK);
    rsp_ready = 1'b1;
    wait_idle();

    // write mask
    send(1'b1, 11'h020, 8'd0, 8'hFF, 8'hFF);
    chk("wem_full", 32'(WEM), 32'hFF);
    send(1'b1, 11'h020, 8'd0, 8'h00, 8'h0F);
`ifdef BRAM_INIT_WEM_EN
    chk("wem_part", 32'(WEM), 32'h0F);
`else
    chk("wem_part", 32'(WEM), 32'hFF);
`endif
    send(1'b0, 11'h020, 8'd0, 8'h00, 8'h00);
    chk("wem_read", 32'(WEM), 32'd0);
    wait_idle();

    // back-to-back writes then burst read-back
    for (int i = 0; i < 16; i++) begin
      send(1'b1, AW'(i), 8'd0, 8'hA0 + DW'(i), 8'hFF);
      chk("b2b_WE", 32'(WE), 32'd1);
      chk("b2b_A", 32'(A), 32'(i));
    end
    @(negedge CLK);
    chk("b2b_WE_end", 32'(WE), 32'd0);
    send(1'b0, 11'd0, 8'd15, 8'h00, 8'h00);
    wait_idle();

    // reset during beat 3 of an 8-beat burst
    send(1'b0, 11'h100, 8'd7, 8'h00, 8'h00);
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_CE", 32'(CE), 32'd1);
    chk("mid_A", 32'(A), 32'h102);
    RST = 1'b1;
    @(negedge CLK);
    chk_rst("mid_rst");
    exp_q.delete();
    RST = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge CLK);
      seen += int'(rsp_valid);
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);
    send(1'b0, 11'h010, 8'd0, 8'h00, 8'h00);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
